// File: rtl/apb_master_bridge.sv
// APB initiator: turns a valid/ready command stream into APB SETUP/ACCESS transfers
// and returns read data and status on a valid/ready response stream, with wait-state timeout.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   wait_inc;
  logic             accept;
  logic             done_ok;
  logic             done_to;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && (state == IDLE);

  // One extra bit so a saturated counter can never alias the timeout limit.
  assign wait_inc = {1'b0, wait_cnt} + (CNT_W + 1)'(1);
  assign done_ok  = (state == ACCESS) && PREADY;
  assign done_to  = (state == ACCESS) && !PREADY && (TIMEOUT_CYCLES != 0)
                    && (wait_inc == TIMEOUT_LIM);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid)          state_next = SETUP;
      SETUP:                           state_next = ACCESS;
      ACCESS:  if (done_ok || done_to) state_next = RESP;
      RESP:    if (rsp_ready)          state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // Bus strobes and rsp_valid are registered from the next state so they are glitch-free.
  // NOTE: every flop here is reset asynchronously so PSEL/PENABLE drop the moment
  // PRESETn asserts, without waiting for a clock.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      PSEL      <= (state_next == SETUP) || (state_next == ACCESS);
      PENABLE   <= (state_next == ACCESS);
      rsp_valid <= (state_next == RESP);

      if (accept) begin
        PWRITE   <= cmd_write;
        PADDR    <= cmd_addr;
        PWDATA   <= cmd_wdata;
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !PREADY && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (done_ok) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (done_to) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, randomized
// transfers against a rule-level model, back-to-back and mid-transfer reset sequences.
module tb_apb_master_bridge;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSEL, PENABLE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            waits;   // PREADY-low ACCESS cycles the slave inserts
    logic [DW-1:0] rd;
    logic          se;
    int            stall;   // cycles rsp_ready is held low
    int            exp_acc;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    logic          exp_to;
  } vec_t;

  // Response rules stated directly: a slave that never answers within TO cycles is aborted.
  function automatic void model(input logic w, input int waits, input logic [DW-1:0] rd,
                                input logic se, output int acc, output logic [DW-1:0] r,
                                output logic err, output logic to);
    to  = (TO != 0) && (waits >= TO);
    acc = to ? TO : waits + 1;
    err = to || se;
    r   = (to || w) ? '0 : rd;
  endfunction

  task automatic run_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int waits, input logic [DW-1:0] rd, input logic se,
                          input int stall, output int acc, output logic [DW-1:0] r_rd,
                          output logic r_err, output logic r_to);
    bit done;
    @(negedge PCLK);
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    @(negedge PCLK);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    check("setup_ctrl", {PSEL, PENABLE, cmd_ready, rsp_valid}, 4'b1000);
    check("setup_bus", {PWRITE, PADDR, PWDATA}, {w, a, wd});
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = DW'($urandom);
    acc = 0;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        acc++;
        check("access_bus", {PWRITE, PADDR, PWDATA, rsp_valid, cmd_ready}, {w, a, wd, 2'b00});
        if (acc > waits) begin
          PREADY = 1; PRDATA = rd; PSLVERR = se;
        end else begin
          PREADY = 0; PRDATA = DW'($urandom); PSLVERR = 1'($urandom);
        end
      end else begin
        done = 1;
      end
    end
    if (!done) check("access_bound", 0, 1);
    PREADY = 0; PSLVERR = 0;
    check("resp_ctrl", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0010);
    r_rd = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 0;
      cmd_valid = 1; cmd_addr = ~a; cmd_write = ~w;
      @(negedge PCLK);
      check("resp_hold", {rsp_valid, PSEL, cmd_ready, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWRITE},
                         {1'b1, 1'b0, 1'b0, r_rd, r_err, r_to, a, w});
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(negedge PCLK);
    rsp_ready = 0;
    check("back_idle", {rsp_valid, PSEL, PENABLE, cmd_ready, PADDR, PWRITE},
                       {1'b0, 1'b0, 1'b0, 1'b1, a, w});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 7'b0000001);
    check({tag, "_data"}, {PADDR, PWDATA, rsp_rdata}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[8];
    int            acc, e_acc;
    logic [DW-1:0] r_rd, e_rd;
    logic          r_err, r_to, e_err, e_to;
    logic          w, se;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    int            waits;

    //          w     a     wd     waits rd     se    stall acc rd     err   to
    vecs[0] = '{1'b1, 3'd2, 8'h5A, 0,    8'h33, 1'b0, 0,    1,  8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 8'h11, 3,    8'hFA, 1'b0, 1,    4,  8'hFA, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'd6, 8'h00, 1,    8'h3C, 1'b1, 2,    2,  8'h3C, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 3'd7, 8'h00, 255,  8'h99, 1'b0, 0,    16, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 3'd1, 8'hA5, 16,   8'h77, 1'b0, 0,    16, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 3'd4, 8'h00, 15,   8'h81, 1'b0, 0,    16, 8'h81, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 3'd5, 8'h0F, 2,    8'h44, 1'b1, 1,    3,  8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 3'd3, 8'h00, 0,    8'hC3, 1'b0, 3,    1,  8'hC3, 1'b0, 1'b0};

    PRESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; PRDATA = '0; PREADY = 0; PSLVERR = 0;
    repeat (3) @(negedge PCLK);
    check_reset_values("reset");
    PRESETn = 1;
    @(negedge PCLK);
    check_reset_values("post_reset");

    foreach (vecs[i]) begin
      run_xfer(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].waits, vecs[i].rd, vecs[i].se,
               vecs[i].stall, acc, r_rd, r_err, r_to);
      check($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
      check($sformatf("vec%0d_rsp", i), {r_rd, r_err, r_to}, {vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_to});
    end

    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom); a = AW'($urandom); wd = DW'($urandom); rd = DW'($urandom);
      se = ($urandom_range(0, 3) == 0);
      waits = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 19) : $urandom_range(0, 4);
      model(w, waits, rd, se, e_acc, e_rd, e_err, e_to);
      run_xfer(w, a, wd, waits, rd, se, $urandom_range(0, 2), acc, r_rd, r_err, r_to);
      check($sformatf("rnd%0d_acc", i), acc, e_acc);
      check($sformatf("rnd%0d_rsp", i), {r_rd, r_err, r_to}, {e_rd, e_err, e_to});
    end

    // Back-to-back: cmd_valid held across four reads, second response stalled 3 cycles.
    begin
      logic [DW-1:0] exp_q[$];
      int  accepted = 0, got = 0, hold = 0, setups = 0;
      bit  will_accept = 0;
      @(negedge PCLK);
      PREADY = 1; PSLVERR = 0; rsp_ready = 1;
      cmd_write = 0; cmd_wdata = '0; cmd_addr = '0; cmd_valid = 1;
      will_accept = cmd_ready;
      for (int c = 0; c < 100 && got < 4; c++) begin
        @(negedge PCLK);
        if (will_accept) begin
          exp_q.push_back({5'b10100, AW'(accepted)});
          accepted++;
        end
        if (PSEL && !PENABLE) setups++;
        if (rsp_valid) begin
          check("b2b_resp_idle_bus", {PSEL, PENABLE, cmd_ready}, 3'b000);
          if (got == 1 && hold < 3) begin
            hold++;
            rsp_ready = 0;
          end else begin
            rsp_ready = 1;
            check($sformatf("b2b_rsp%0d", got), {rsp_rdata, rsp_err, rsp_timeout},
                  {(exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx, 2'b00});
            got++;
          end
        end else begin
          rsp_ready = 1;
        end
        PRDATA    = {5'b10100, PADDR};
        cmd_addr  = AW'(accepted);
        cmd_valid = (accepted < 4);
        will_accept = cmd_valid && cmd_ready;
      end
      cmd_valid = 0;
      check("b2b_count", {8'(got), 8'(accepted), 8'(setups)}, {8'd4, 8'd4, 8'd4});
      @(negedge PCLK);
      rsp_ready = 0;
      check("b2b_idle", {cmd_ready, rsp_valid, PSEL}, 3'b100);
    end

    // Reset asserted mid-ACCESS with the slave stalling.
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd5; cmd_wdata = 8'hE7; PREADY = 0;
    @(negedge PCLK);
    cmd_valid = 0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_pre_access", {PSEL, PENABLE, PADDR}, {2'b11, 3'd5});
    #2 PRESETn = 0;
    #1 check("rst_async_drop", {PSEL, PENABLE, rsp_valid}, 3'b000);
    check_reset_values("rst_mid");
    @(negedge PCLK);
    PRESETn = 1;
    @(negedge PCLK);
    check_reset_values("rst_release");
    run_xfer(1'b0, 3'd6, 8'h00, 1, 8'h6B, 1'b0, 0, acc, r_rd, r_err, r_to);
    check("rst_after_xfer", {8'(acc), r_rd, r_err, r_to}, {8'd2, 8'h6B, 2'b00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
